ddr2_cmd_issuer: RTL and testbench

Synthesizable host-side command issuer that sits directly upstream of `ddr2_controller` and drives its `CMD/SZ/OP/ADDR/DIN/INITDDR` inputs. It accepts a valid/ready request stream and sequences controller initialisation. It buffers block-write payloads, applies per-request pre-issue wait cycles, and holds each command until the controller's `NOTFULL`/`FILLCOUNT` back-pressure allows consumption.

---
 rtl/ddr2_pkg.sv | 58 +++++
 rtl/ddr2_blw_buffer.sv | 25 ++
 rtl/ddr2_cmd_issuer.sv | 183 ++++++++++++++++++
 tb/tb_ddr2_cmd_issuer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared encodings, FSM states and helpers for the DDR2 command issuer.
package ddr2_pkg;

    localparam int BLW_MAX_WORDS  = 32;
    localparam int DATA_SPACE_MAX = 63;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_SCR  = 3'd1,
        CMD_SCW  = 3'd2,
        CMD_BLR  = 3'd3,
        CMD_BLW  = 3'd4,
        CMD_ATR  = 3'd5,
        CMD_ATW  = 3'd6,
        CMD_NOP7 = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_RDY,
        ST_IDLE,
        ST_COLLECT,
        ST_DELAY,
        ST_ISSUE,
        ST_BLW_DATA
    } state_e;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [1:0]  sz;
        logic [2:0]  op;
        logic [24:0] addr;
        logic [15:0] din;
    } cmd_bus_t;

    function automatic logic [5:0] blw_words(input logic [1:0] sz);
        return {1'b0, sz, 3'b000} + 6'd8;
    endfunction

    // Builds the controller-facing bus with every don't-care field forced to 0.
    function automatic cmd_bus_t mk_bus(input logic [2:0] cmd, input logic [1:0] sz,
                                        input logic [2:0] op, input logic [24:0] addr,
                                        input logic [15:0] din);
        cmd_bus_t b;
        b = '0;
        if (cmd != CMD_NOP && cmd != CMD_NOP7) begin
            b.cmd  = cmd;
            b.addr = addr;
            b.din  = din;
            if (cmd inside {CMD_BLR, CMD_BLW, CMD_ATR, CMD_ATW}) begin
                b.sz = sz;
                b.op = op;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ddr2_blw_buffer.sv
// Block-write payload store: one write port fed during collection, one
// combinational read port walked by the issuing FSM. Contents survive reset.
module ddr2_blw_buffer
    import ddr2_pkg::*;
#(
    parameter int DEPTH = BLW_MAX_WORDS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ddr2_cmd_issuer.sv
// Host-side issuer in front of ddr2_controller: init sequencing, request
// acceptance, block-write buffering, pre-issue waits and back-pressure hold.
module ddr2_cmd_issuer
    import ddr2_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [7:0]  REQ_WAIT,
    input  logic [2:0]  REQ_CMD,
    input  logic [1:0]  REQ_SZ,
    input  logic [2:0]  REQ_OP,
    input  logic [24:0] REQ_ADDR,
    input  logic [15:0] REQ_DATA,
    input  logic        NOTFULL,
    input  logic [6:0]  FILLCOUNT,
    input  logic        READY,
    output logic        INITDDR,
    output logic [2:0]  CMD,
    output logic [1:0]  SZ,
    output logic [2:0]  OP,
    output logic [24:0] ADDR,
    output logic [15:0] DIN,
    output logic        BUSY,
    output logic [15:0] ISSUED
);

    localparam int AW = $clog2(BLW_MAX_WORDS);

    state_e      state_q, state_d;
    cmd_bus_t    bus_q, bus_d;
    cmd_bus_t    hdr_q, hdr_d;
    logic        initddr_q, initddr_d;
    logic [15:0] issued_q, issued_d;
    logic [7:0]  wait_q, wait_d;
    logic [AW-1:0] idx_q, idx_d;

    logic          accept, cons, space_ok, last_word;
    logic [5:0]    words;
    logic [AW-1:0] rd_idx;
    logic [15:0]   rdata;
    cmd_bus_t      issue_bus;

    ddr2_blw_buffer #(.DEPTH(BLW_MAX_WORDS), .AW(AW)) u_buf (
        .clk_i   (CLK),
        .we_i    (state_q == ST_COLLECT && REQ_VALID),
        .waddr_i (idx_q),
        .wdata_i (REQ_DATA),
        .raddr_i (rd_idx),
        .rdata_o (rdata)
    );

    assign REQ_READY = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign BUSY      = (state_q != ST_IDLE);
    assign accept    = REQ_VALID && REQ_READY;
    assign space_ok  = (FILLCOUNT <= 7'(DATA_SPACE_MAX));
    assign words     = blw_words(hdr_q.sz);
    assign last_word = (6'(idx_q) == words - 6'd1);
    assign issue_bus = mk_bus(hdr_q.cmd, hdr_q.sz, hdr_q.op, hdr_q.addr,
                              (hdr_q.cmd == CMD_BLW) ? rdata : hdr_q.din);

    // Read port looks one word ahead so the next DIN is ready on consume.
    always_comb begin
        rd_idx = '0;
        case (state_q)
            ST_ISSUE:    rd_idx = AW'(1);
            ST_BLW_DATA: rd_idx = idx_q + AW'(1);
            default:     rd_idx = '0;
        endcase
    end

    always_comb begin
        cons = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                case (bus_q.cmd)
                    CMD_NOP, CMD_NOP7: cons = 1'b1;
                    CMD_SCR, CMD_BLR:  cons = NOTFULL;
                    default:           cons = NOTFULL && space_ok;
                endcase
            end
            ST_BLW_DATA: cons = space_ok;
            default:     cons = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        hdr_d     = hdr_q;
        initddr_d = 1'b0;
        issued_d  = issued_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        case (state_q)
            ST_INIT: begin
                initddr_d = 1'b1;
                state_d   = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: if (READY) state_d = ST_IDLE;
            ST_IDLE: if (accept) begin
                hdr_d  = '{cmd: REQ_CMD, sz: REQ_SZ, op: REQ_OP, addr: REQ_ADDR, din: REQ_DATA};
                wait_d = REQ_WAIT;
                idx_d  = '0;
                if (REQ_CMD == CMD_BLW)      state_d = ST_COLLECT;
                else if (REQ_WAIT != 8'd0)   state_d = ST_DELAY;
                else if (REQ_CMD != CMD_NOP && REQ_CMD != CMD_NOP7) begin
                    state_d = ST_ISSUE;
                    bus_d   = mk_bus(REQ_CMD, REQ_SZ, REQ_OP, REQ_ADDR, REQ_DATA);
                end
            end
            ST_COLLECT: if (REQ_VALID) begin
                idx_d = idx_q + AW'(1);
                if (last_word) begin
                    idx_d = '0;
                    if (wait_q != 8'd0) state_d = ST_DELAY;
                    else begin
                        state_d = ST_ISSUE;
                        bus_d   = issue_bus;
                    end
                end
            end
            ST_DELAY: begin
                wait_d = wait_q - 8'd1;
                if (wait_q == 8'd1) begin
                    state_d = ST_ISSUE;
                    bus_d   = issue_bus;
                end
            end
            ST_ISSUE: if (cons) begin
                if (bus_q.cmd != CMD_NOP) issued_d = issued_q + 16'd1;
                bus_d = '0;
                if (bus_q.cmd == CMD_BLW) begin
                    state_d   = ST_BLW_DATA;
                    idx_d     = AW'(1);
                    bus_d.din = rdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLW_DATA: if (cons) begin
                if (last_word) begin
                    state_d = ST_IDLE;
                    bus_d   = '0;
                end else begin
                    idx_d     = idx_q + AW'(1);
                    bus_d.din = rdata;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_INIT;
            bus_q     <= '0;
            hdr_q     <= '0;
            initddr_q <= 1'b0;
            issued_q  <= '0;
            wait_q    <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            hdr_q     <= hdr_d;
            initddr_q <= initddr_d;
            issued_q  <= issued_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
        end
    end

    assign INITDDR = initddr_q;
    assign CMD     = bus_q.cmd;
    assign SZ      = bus_q.sz;
    assign OP      = bus_q.op;
    assign ADDR    = bus_q.addr;
    assign DIN     = bus_q.din;
    assign ISSUED  = issued_q;

endmodule

// File: tb/tb_ddr2_cmd_issuer.sv
// Directed timing checks followed by a randomized request stream scored
// against a transaction-level queue of expected controller beats.
`timescale 1ns/1ps
module tb_ddr2_cmd_issuer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [7:0]  REQ_WAIT = '0;
    logic [2:0]  REQ_CMD = '0;
    logic [1:0]  REQ_SZ = '0;
    logic [2:0]  REQ_OP = '0;
    logic [24:0] REQ_ADDR = '0;
    logic [15:0] REQ_DATA = '0;
    wire         NOTFULL;
    wire  [6:0]  FILLCOUNT;
    logic        READY = 1'b0;
    logic        INITDDR, BUSY;
    logic [2:0]  CMD, OP;
    logic [1:0]  SZ;
    logic [24:0] ADDR;
    logic [15:0] DIN, ISSUED;

    logic       bp_rand = 1'b0, nf_dir = 1'b1, nf_rnd = 1'b1;
    logic [6:0] fc_dir = '0, fc_rnd = '0;
    assign NOTFULL   = bp_rand ? nf_rnd : nf_dir;
    assign FILLCOUNT = bp_rand ? fc_rnd : fc_dir;

    int n_tests = 0, n_fail = 0;
    int exp_issued = 0;
    bit mon_en = 1'b0;
    logic [48:0] exp_q[$];

    ddr2_cmd_issuer dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WAIT(REQ_WAIT), .REQ_CMD(REQ_CMD), .REQ_SZ(REQ_SZ), .REQ_OP(REQ_OP),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .NOTFULL(NOTFULL), .FILLCOUNT(FILLCOUNT),
        .READY(READY), .INITDDR(INITDDR), .CMD(CMD), .SZ(SZ), .OP(OP), .ADDR(ADDR),
        .DIN(DIN), .BUSY(BUSY), .ISSUED(ISSUED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive point: shortly after the falling edge; outputs are stable here.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [48:0] mkexp(input logic [2:0] c, input logic [1:0] sz,
                                          input logic [2:0] op, input logic [24:0] a,
                                          input logic [15:0] d);
        bit blk;
        if (c == 3'd0 || c == 3'd7) return '0;
        blk = (c >= 3'd3 && c <= 3'd6);
        return {c, blk ? sz : 2'b0, blk ? op : 3'b0, a, d};
    endfunction

    task automatic drive_req(input logic [2:0] c, input logic [1:0] sz, input logic [2:0] op,
                             input logic [24:0] a, input logic [15:0] d, input logic [7:0] w);
        REQ_CMD = c; REQ_SZ = sz; REQ_OP = op; REQ_ADDR = a; REQ_DATA = d; REQ_WAIT = w;
        REQ_VALID = 1'b1;
    endtask

    // Holds the beat until a rising edge sees REQ_READY, bounded.
    task automatic send(input logic [2:0] c, input logic [1:0] sz, input logic [2:0] op,
                        input logic [24:0] a, input logic [15:0] d, input logic [7:0] w);
        bit acc, rdy;
        acc = 1'b0;
        drive_req(c, sz, op, a, d, w);
        for (int g = 0; g < 2000 && !acc; g++) begin
            rdy = REQ_READY;
            tick();
            acc = rdy;
        end
        chk("accept", acc, 1'b1);
        REQ_VALID = 1'b0;
    endtask

    // Random back-pressure source.
    initial forever begin
        @(negedge CLK);
        #1;
        nf_rnd = ($urandom_range(0, 3) != 0);
        fc_rnd = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(64, 70)) : 7'($urandom_range(0, 63));
    end

    // Monitor: decides consumption from the controller-side rules and scores beats.
    int          data_left = 0;
    bit          prev_stall = 1'b0;
    logic [48:0] prev_bus = '0;

    task automatic take(input string tag, input logic [48:0] cur);
        logic [48:0] e;
        if (exp_q.size() == 0) chk("spurious_beat", exp_q.size(), 1);
        else begin
            e = exp_q.pop_front();
            chk(tag, cur, e);
        end
    endtask

    task automatic mon_step();
        logic [48:0] cur;
        bit c;
        cur = {CMD, SZ, OP, ADDR, DIN};
        if (prev_stall) chk("stall_hold", cur, prev_bus);
        c = 1'b0;
        if (data_left > 0) begin
            c = (FILLCOUNT <= 7'd63);
            if (c) begin
                take("blw_data", cur);
                data_left--;
            end
        end else if (CMD != 3'd0) begin
            case (CMD)
                3'd1, 3'd3: c = NOTFULL;
                3'd7:       c = 1'b1;
                default:    c = NOTFULL && (FILLCOUNT <= 7'd63);
            endcase
            if (c) begin
                take("header", cur);
                if (CMD == 3'd4) data_left = 8 * (int'(SZ) + 1) - 1;
            end
        end
        prev_stall = (data_left > 0 || CMD != 3'd0) && !c;
        prev_bus   = cur;
    endtask

    initial forever begin
        @(negedge CLK);
        #2;
        if (mon_en) mon_step();
    end

    initial begin : main
        int w;
        bit stalled;
        logic [15:0] wd [32];
        logic [2:0]  c;
        logic [1:0]  sz;
        logic [2:0]  op;
        logic [24:0] a;
        logic [15:0] d;
        logic [7:0]  wt;
        int nw;

        // Reset and init handshake
        repeat (2) tick();
        chk("rst_outs", {INITDDR, CMD, SZ, OP, ADDR, DIN, ISSUED, REQ_READY}, '0);
        RESET_N = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("initddr", INITDDR, (i == 1));
            chk("rdy_pre", REQ_READY, 1'b0);
            chk("outs_pre", {CMD, ADDR, DIN, ISSUED}, '0);
            if (i == 20) READY = 1'b1;
        end
        tick();
        chk("rdy_up", REQ_READY, 1'b1);
        chk("busy_idle", BUSY, 1'b0);

        // SCW held by FILLCOUNT=64 for 5 cycles
        drive_req(3'd2, 2'd3, 3'd7, 25'h1BABAFE, 16'hCAFE, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            REQ_VALID = 1'b0;
            chk("scw_cmd", CMD, 3'd2);
            if (k == 1) chk("scw_bus", {SZ, OP, ADDR, DIN}, {2'd0, 3'd0, 25'h1BABAFE, 16'hCAFE});
            fc_dir = (k < 6) ? 7'd64 : 7'd10;
        end
        tick();
        chk("scw_done", CMD, 3'd0);
        chk("scw_issued", ISSUED, 16'd1);

        // SCR held by NOTFULL only, FILLCOUNT above data space is irrelevant
        drive_req(3'd1, 2'd0, 3'd0, 25'h0123456, 16'h5A5A, 8'd0);
        nf_dir = 1'b0;
        fc_dir = 7'd70;
        for (int k = 1; k <= 4; k++) begin
            tick();
            REQ_VALID = 1'b0;
            chk("scr_cmd", CMD, 3'd1);
            nf_dir = (k < 4) ? 1'b0 : 1'b1;
        end
        tick();
        chk("scr_done", CMD, 3'd0);
        chk("scr_issued", ISSUED, 16'd2);
        fc_dir = 7'd10;

        // BLW SZ=1: 16 collected words, stall on word 7
        drive_req(3'd4, 2'd1, 3'd5, 25'h0000ABC, 16'hDEAD, 8'd0);
        for (int b = 0; b < 16; b++) begin
            tick();
            REQ_DATA = 16'(b);
            chk("blw_collect", {REQ_READY, CMD}, {1'b1, 3'd0});
        end
        tick();
        REQ_VALID = 1'b0;
        chk("blw_hdr", {CMD, SZ, OP, ADDR, DIN}, {3'd4, 2'd1, 3'd5, 25'h0000ABC, 16'h0000});
        w = 1;
        stalled = 1'b0;
        while (w < 16) begin
            tick();
            chk("blw_din", DIN, 16'(w));
            chk("blw_cmd0", CMD, 3'd0);
            if (w == 7 && !stalled) begin
                fc_dir = 7'd64;
                stalled = 1'b1;
            end else begin
                fc_dir = 7'd10;
                w++;
            end
        end
        tick();
        chk("blw_end", {CMD, DIN, REQ_READY}, {3'd0, 16'd0, 1'b1});
        chk("blw_issued", ISSUED, 16'd3);

        // SCR with 10 wait cycles
        drive_req(3'd1, 2'd0, 3'd0, 25'h1000001, 16'h0001, 8'd10);
        for (int k = 1; k <= 10; k++) begin
            tick();
            REQ_VALID = 1'b0;
            chk("dly_nop", CMD, 3'd0);
        end
        tick();
        chk("dly_cmd", CMD, 3'd1);
        tick();
        chk("dly_issued", ISSUED, 16'd4);

        // Asynchronous reset in the middle of BLW data
        drive_req(3'd4, 2'd0, 3'd2, 25'h0000777, 16'h0, 8'd0);
        for (int b = 0; b < 8; b++) begin
            tick();
            REQ_DATA = 16'h0100 + 16'(b);
        end
        tick();
        REQ_VALID = 1'b0;
        chk("blw2_hdr", {CMD, DIN}, {3'd4, 16'h0100});
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("blw2_din", DIN, 16'h0100 + 16'(k));
        end
        chk("blw2_issued", ISSUED, 16'd5);
        RESET_N = 1'b0;
        #1;
        chk("arst_outs", {INITDDR, CMD, SZ, OP, ADDR, DIN, ISSUED, REQ_READY}, '0);
        tick();
        RESET_N = 1'b1;
        tick();
        chk("reinit", INITDDR, 1'b1);
        tick();
        chk("reinit_end", {INITDDR, REQ_READY}, {1'b0, 1'b1});
        chk("reinit_issued", ISSUED, 16'd0);

        // Randomized stream under random back-pressure
        exp_issued = 0;
        data_left  = 0;
        prev_stall = 1'b0;
        mon_en  = 1'b1;
        bp_rand = 1'b1;
        for (int r = 0; r < 60; r++) begin
            c  = 3'($urandom_range(0, 7));
            sz = 2'($urandom);
            op = 3'($urandom);
            a  = 25'($urandom);
            d  = 16'($urandom);
            wt = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            nw = 8 * (int'(sz) + 1);
            for (int i = 0; i < nw; i++) wd[i] = 16'($urandom);
            if (c != 3'd0 && c != 3'd7) begin
                exp_issued++;
                exp_q.push_back(mkexp(c, sz, op, a, (c == 3'd4) ? wd[0] : d));
                if (c == 3'd4)
                    for (int i = 1; i < nw; i++) exp_q.push_back({33'd0, wd[i]});
            end
            send(c, sz, op, a, d, wt);
            if (c == 3'd4)
                for (int i = 0; i < nw; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(3'($urandom), 2'($urandom), 3'($urandom), 25'($urandom), wd[i], 8'($urandom));
                end
            if ($urandom_range(0, 2) == 0) tick();
        end
        for (int g = 0; g < 3000 && exp_q.size() != 0; g++) tick();
        repeat (3) tick();
        chk("q_drained", exp_q.size(), 0);
        chk("issued_total", ISSUED, 16'(exp_issued));
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
